// File: rtl/gcd_pkg.sv
// gcd_pkg: shared width, client FSM states and request packing for the GCD engine
package gcd_pkg;

    localparam int WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        HOLD
    } gcd_client_state_e;

    // Engine input bus layout: operand B in the upper half, operand A in the lower half
    function automatic logic [2*WIDTH-1:0] pack_req(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return {b, a};
    endfunction

endpackage

// File: rtl/gcd_client.sv
// gcd_client: requester front end for the GCD engine with zero-operand bypass and watchdog
module gcd_client
    import gcd_pkg::*;
#(
    parameter int WIDTH          = gcd_pkg::WIDTH,
    parameter int TIMEOUT_CYCLES = 131072
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    input  logic [WIDTH-1:0]   req_a,
    input  logic [WIDTH-1:0]   req_b,
    output logic               req_ready,
    output logic               gcd_in_valid,
    output logic [2*WIDTH-1:0] gcd_in_data,
    input  logic               gcd_in_ready,
    input  logic               gcd_out_valid,
    input  logic [WIDTH-1:0]   gcd_out_data,
    output logic               rsp_valid,
    output logic [WIDTH-1:0]   rsp_data,
    output logic               rsp_timeout,
    input  logic               rsp_ready,
    output logic               err_timeout,
    output logic [15:0]        done_count
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);

    gcd_client_state_e state_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  result_q;
    logic [TW-1:0]     timer_q;
    logic              timeout_q;
    logic              err_q;
    logic [15:0]       done_q;

    // Request FSM: capture, issue to engine, wait with watchdog, hold response until taken
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            a_q       <= '0;
            b_q       <= '0;
            result_q  <= '0;
            timer_q   <= '0;
            timeout_q <= 1'b0;
            err_q     <= 1'b0;
            done_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        a_q <= req_a;
                        b_q <= req_b;
                        if (req_a == '0) begin
                            result_q  <= req_b;
                            timeout_q <= 1'b0;
                            state_q   <= HOLD;
                        end else begin
                            state_q <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (gcd_in_ready) begin
                        timer_q <= '0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (gcd_out_valid) begin
                        result_q <= gcd_out_data;
                        state_q  <= HOLD;
                    end else if (timer_q == TIMER_LAST) begin
                        result_q  <= '0;
                        timeout_q <= 1'b1;
                        err_q     <= 1'b1;
                        state_q   <= HOLD;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                HOLD: begin
                    if (rsp_ready) begin
                        done_q    <= done_q + 16'd1;
                        timeout_q <= 1'b0;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Output decode from state and registers only
    always_comb begin
        req_ready    = state_q == IDLE;
        gcd_in_valid = state_q == ISSUE;
        gcd_in_data  = gcd_in_valid ? pack_req(a_q, b_q) : '0;
        rsp_valid    = state_q == HOLD;
        rsp_data     = rsp_valid ? result_q : '0;
        rsp_timeout  = timeout_q;
        err_timeout  = err_q;
        done_count   = done_q;
    end

endmodule

// File: tb/tb_gcd_client.sv
// tb_gcd_client: directed and random requests against a GCD reference, with a behavioural engine stub
module tb_gcd_client;
    import gcd_pkg::*;

    localparam int W  = 16;
    localparam int TO = 8;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           req_valid = 1'b0;
    logic [W-1:0]   req_a = '0;
    logic [W-1:0]   req_b = '0;
    logic           req_ready;
    logic           gcd_in_valid;
    logic [2*W-1:0] gcd_in_data;
    logic           gcd_in_ready;
    logic           gcd_out_valid = 1'b0;
    logic [W-1:0]   gcd_out_data = '0;
    logic           rsp_valid;
    logic [W-1:0]   rsp_data;
    logic           rsp_timeout;
    logic           rsp_ready = 1'b0;
    logic           err_timeout;
    logic [15:0]    done_count;

    int n_cmp = 0;
    int n_err = 0;
    int done_m = 0;
    logic err_m = 1'b0;

    always #5 clk = ~clk;

    gcd_client #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
        .gcd_in_valid(gcd_in_valid), .gcd_in_data(gcd_in_data), .gcd_in_ready(gcd_in_ready),
        .gcd_out_valid(gcd_out_valid), .gcd_out_data(gcd_out_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout), .rsp_ready(rsp_ready),
        .err_timeout(err_timeout), .done_count(done_count)
    );

    function automatic logic [W-1:0] gcd_ref(input logic [W-1:0] a, input logic [W-1:0] b);
        int unsigned x = a;
        int unsigned y = b;
        int unsigned t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return W'(x);
    endfunction

    // Engine stub: accepts when idle, pulses the gcd of what it received eng_lat cycles after the handshake
    int eng_lat = 1;
    int eng_cnt = 0;
    logic eng_busy = 1'b0;
    logic [W-1:0] eng_res = '0;
    assign gcd_in_ready = !eng_busy;
    always @(posedge clk) begin
        gcd_out_valid <= 1'b0;
        gcd_out_data  <= W'($urandom);
        if (eng_busy) begin
            if (eng_cnt == 1) begin
                gcd_out_valid <= 1'b1;
                gcd_out_data  <= eng_res;
                eng_busy      <= 1'b0;
            end
            eng_cnt <= eng_cnt - 1;
        end else if (gcd_in_valid) begin
            eng_busy <= 1'b1;
            eng_cnt  <= eng_lat;
            eng_res  <= gcd_ref(gcd_in_data[W-1:0], gcd_in_data[2*W-1:W]);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One request from an IDLE negedge through response acceptance; latency checked when the engine is free
    task automatic run_req(input logic [W-1:0] a, input logic [W-1:0] b, input int lat_eng,
                           input int hold, input bit chk_lat);
        int lat;
        bit saw_in;
        bit tmo;
        logic [W-1:0] exp_d;
        tmo   = (a != 0) && (lat_eng >= TO);
        exp_d = (a == 0) ? b : (tmo ? '0 : gcd_ref(a, b));
        chk("req_ready_idle", 32'(req_ready), 1);
        eng_lat   = lat_eng;
        req_valid = 1'b1;
        req_a     = a;
        req_b     = b;
        @(negedge clk);
        req_valid = 1'b0;
        lat    = 1;
        saw_in = 1'b0;
        while (!rsp_valid && lat < 200) begin
            if (gcd_in_valid && !saw_in) begin
                saw_in = 1'b1;
                chk("in_data", gcd_in_data, {16'(b), 16'(a)});
            end
            @(negedge clk);
            lat++;
        end
        chk("rsp_valid", 32'(rsp_valid), 1);
        if (chk_lat)
            chk("latency", lat, (a == 0) ? 1 : 3 + ((lat_eng < TO - 1) ? lat_eng : TO - 1));
        chk("issued", 32'(saw_in), 32'(a != 0));
        err_m = err_m | tmo;
        chk("rsp_data", 32'(rsp_data), 32'(exp_d));
        chk("rsp_timeout", 32'(rsp_timeout), 32'(tmo));
        chk("err_timeout", 32'(err_timeout), 32'(err_m));
        chk("req_ready_hold", 32'(req_ready), 0);
        repeat (hold) begin
            @(negedge clk);
            chk("hold_valid", 32'(rsp_valid), 1);
            chk("hold_data", 32'(rsp_data), 32'(exp_d));
            chk("hold_tmo", 32'(rsp_timeout), 32'(tmo));
            chk("hold_req_ready", 32'(req_ready), 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        done_m = (done_m + 1) & 16'hFFFF;
        chk("rsp_released", 32'(rsp_valid), 0);
        chk("rsp_timeout_clr", 32'(rsp_timeout), 0);
        chk("done_count", 32'(done_count), 32'(done_m));
        if (tmo) begin
            repeat (lat_eng + 2) begin
                @(negedge clk);
                chk("late_ignored", 32'(rsp_valid), 0);
            end
            chk("late_done_count", 32'(done_count), 32'(done_m));
        end
    endtask

    initial begin
        #1;
        chk("rst_req_ready", 32'(req_ready), 1);
        chk("rst_rsp_valid", 32'(rsp_valid), 0);
        chk("rst_in_valid", 32'(gcd_in_valid), 0);
        chk("rst_done", 32'(done_count), 0);
        chk("rst_err", 32'(err_timeout), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_req(16'd48, 16'd18, 3, 0, 1);
        run_req(16'd0, 16'd9, 1, 0, 1);
        run_req(16'd0, 16'd0, 1, 0, 1);
        run_req(16'd7, 16'd0, 1, 0, 1);
        run_req(16'd35, 16'd21, 2, 5, 1);
        run_req(16'd100, 16'd75, TO - 1, 1, 1);
        run_req(16'd100, 16'd75, 20, 2, 1);
        run_req(16'd9, 16'd6, 2, 0, 1);
        // Abort a request mid-WAIT; the engine keeps draining the abandoned job
        eng_lat   = 20;
        req_valid = 1'b1;
        req_a     = 16'd30;
        req_b     = 16'd45;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_in_wait", 32'(gcd_in_valid | rsp_valid | req_ready), 0);
        reset = 1'b0;
        #1;
        chk("arst_req_ready", 32'(req_ready), 1);
        chk("arst_rsp_valid", 32'(rsp_valid), 0);
        chk("arst_in_valid", 32'(gcd_in_valid), 0);
        chk("arst_in_data", gcd_in_data, 0);
        chk("arst_rsp_data", 32'(rsp_data), 0);
        chk("arst_done", 32'(done_count), 0);
        chk("arst_err", 32'(err_timeout), 0);
        done_m = 0;
        err_m  = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_rsp_valid", 32'(rsp_valid), 0);
        run_req(16'd12, 16'd8, 2, 0, 0);
        for (int i = 0; i < 30; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = ($urandom_range(0, 4) == 0) ? '0 : W'($urandom);
            b = ($urandom_range(0, 5) == 0) ? '0 : W'($urandom);
            run_req(a, b, $urandom_range(1, TO + 2), $urandom_range(0, 3), 1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
